// File: rtl/mem_pkg.sv
// mem_pkg: shared sizing helpers and parameter checks for the masked 1R1W memory.
package mem_pkg;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic int lane_count(input int width, input int gran);
    return width / gran;
  endfunction
  function automatic bit gran_ok(input int width, input int gran);
    return gran > 0 && width % gran == 0;
  endfunction
endpackage

// File: rtl/mem_lane_valid.sv
// mem_lane_valid: per-address, per-lane valid flops with async reset, flush and set-on-write.
module mem_lane_valid
  import mem_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int LANES  = 4,
  parameter int ADDR_W = 7
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LANES-1:0]  wr_mask,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [LANES-1:0]  rd_lv
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  logic [LANES-1:0] lv_q [DEPTH];
  logic [LANES-1:0] lv_d [DEPTH];
  logic wr_ok, rd_ok;
  always_comb begin
    wr_ok = wr_en && {1'b0, wr_addr} < DEPTH_L;
    rd_ok = {1'b0, rd_addr} < DEPTH_L;
    for (int i = 0; i < DEPTH; i++) lv_d[i] = flush ? '0 : lv_q[i];
    // a write in the flush cycle still leaves its own lanes valid
    if (wr_ok) lv_d[wr_addr] = lv_d[wr_addr] | wr_mask;
    rd_lv = rd_ok ? lv_q[rd_addr] : '0;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) for (int i = 0; i < DEPTH; i++) lv_q[i] <= '0;
    else lv_q <= lv_d;
endmodule

// File: rtl/mem_1r1w_masked_vt.sv
// mem_1r1w_masked_vt: single-clock masked 1R1W memory with lane-valid tracking,
// optional write-to-read bypass, idle output hold and synchronous flush.
module mem_1r1w_masked_vt
  import mem_pkg::*;
#(
  parameter int DEPTH     = 128,
  parameter int WIDTH     = 4,
  parameter int MASK_GRAN = 1,
  parameter int BYPASS    = 1,
  localparam int ADDR_W   = clog2_min1(DEPTH),
  localparam int MASK_W   = lane_count(WIDTH, MASK_GRAN)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] R0_addr,
  input  logic              R0_en,
  output logic [WIDTH-1:0]  R0_data,
  output logic              R0_valid,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic              W0_en,
  input  logic [WIDTH-1:0]  W0_data,
  input  logic [MASK_W-1:0] W0_mask,
  input  logic              flush
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  if (!gran_ok(WIDTH, MASK_GRAN)) begin : g_bad_gran
    $error("WIDTH must be a multiple of MASK_GRAN");
  end
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] r0_data_q, r0_data_d, wm, lvm, old_data, rd_data;
  logic [MASK_W-1:0] rd_lv;
  logic r0_valid_q, r0_valid_d, w_ok, r_ok, hit;
  mem_lane_valid #(.DEPTH(DEPTH), .LANES(MASK_W), .ADDR_W(ADDR_W)) u_lv (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .wr_en   (W0_en),
    .wr_addr (W0_addr),
    .wr_mask (W0_mask),
    .rd_addr (R0_addr),
    .rd_lv   (rd_lv)
  );
  genvar l;
  for (l = 0; l < MASK_W; l++) begin : g_lane
    assign wm[l*MASK_GRAN +: MASK_GRAN]  = {MASK_GRAN{W0_mask[l]}};
    assign lvm[l*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{rd_lv[l]}};
  end
  always_comb begin
    w_ok = W0_en && {1'b0, W0_addr} < DEPTH_L;
    r_ok = {1'b0, R0_addr} < DEPTH_L;
    mem_d = mem_q;
    if (w_ok) mem_d[W0_addr] = (mem_q[W0_addr] & ~wm) | (W0_data & wm);
    old_data = r_ok ? mem_q[R0_addr] & lvm : '0;
    hit = BYPASS != 0 && w_ok && R0_addr == W0_addr;
    rd_data = hit ? (old_data & ~wm) | (W0_data & wm) : old_data;
    r0_data_d = R0_en ? rd_data : r0_data_q;
    r0_valid_d = R0_en;
  end
  always_ff @(posedge clock) mem_q <= mem_d;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r0_data_q <= '0;
      r0_valid_q <= 1'b0;
    end else begin
      r0_data_q <= r0_data_d;
      r0_valid_q <= r0_valid_d;
    end
  assign R0_data = r0_data_q;
  assign R0_valid = r0_valid_q;
endmodule

// File: tb/tb_mem_1r1w_masked_vt.sv
// tb_mem_1r1w_masked_vt: scoreboard bench driving a default instance and a DEPTH=100/BYPASS=0
// instance with identical stimulus, each checked against a lane-level reference model.
module tb_mem_1r1w_masked_vt;
  typedef struct packed {logic v; logic [3:0] d;} exp_t;
  logic clock = 0, reset_n = 0, R0_en = 0, W0_en = 0, flush = 0;
  logic [6:0] R0_addr = 0, W0_addr = 0;
  logic [3:0] W0_data = 0, W0_mask = 0;
  logic [3:0] rd0, rd1;
  logic rv0, rv1;
  int checks = 0, errors = 0;
  exp_t q0[$], q1[$];
  logic [3:0] md [2][128];
  logic [3:0] ml [2][128];
  logic [3:0] held [2];
  int dep [2] = '{128, 100};
  bit byp [2] = '{1'b1, 1'b0};

  always #5 clock = ~clock;

  mem_1r1w_masked_vt u0 (
    .clock(clock), .reset_n(reset_n), .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(rd0),
    .R0_valid(rv0), .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask),
    .flush(flush)
  );
  mem_1r1w_masked_vt #(.DEPTH(100), .BYPASS(0)) u1 (
    .clock(clock), .reset_n(reset_n), .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(rd1),
    .R0_valid(rv1), .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask),
    .flush(flush)
  );

  task automatic cmp(input int k, input logic v, input logic [3:0] d, input exp_t e);
    checks += 2;
    if (v !== e.v) begin
      errors++;
      $display("FAIL u%0d valid got %b exp %b at %0t", k, v, e.v, $time);
    end
    if (d !== e.d) begin
      errors++;
      $display("FAIL u%0d data got %h exp %h at %0t", k, d, e.d, $time);
    end
  endtask

  always @(negedge clock) if (reset_n) begin
    if (q0.size() > 0) cmp(0, rv0, rd0, q0.pop_front());
    if (q1.size() > 0) cmp(1, rv1, rd1, q1.pop_front());
  end

  function automatic logic [3:0] mread(int k, logic [6:0] ra, logic we, logic [6:0] wa,
                                       logic [3:0] wd, logic [3:0] wm);
    logic [3:0] r = 4'h0;
    if (int'(ra) >= dep[k]) return 4'h0;
    for (int b = 0; b < 4; b++)
      if (byp[k] && we && wa == ra && wm[b]) r[b] = wd[b];
      else if (ml[k][ra][b]) r[b] = md[k][ra][b];
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      held[k] = 4'h0;
      for (int a = 0; a < 128; a++) ml[k][a] = 4'h0;
    end
  endtask

  task automatic cycle(input logic re, input logic [6:0] ra, input logic we, input logic [6:0] wa,
                       input logic [3:0] wd, input logic [3:0] wm, input logic fl);
    exp_t e [2];
    R0_en = re; R0_addr = ra; W0_en = we; W0_addr = wa; W0_data = wd; W0_mask = wm; flush = fl;
    for (int k = 0; k < 2; k++) begin
      if (re) held[k] = mread(k, ra, we, wa, wd, wm);
      e[k] = '{re, held[k]};
      if (fl) for (int a = 0; a < 128; a++) ml[k][a] = 4'h0;
      if (we && int'(wa) < dep[k])
        for (int b = 0; b < 4; b++) if (wm[b]) begin
          md[k][wa][b] = wd[b];
          ml[k][wa][b] = 1'b1;
        end
    end
    @(posedge clock);
    q0.push_back(e[0]);
    q1.push_back(e[1]);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_clear();
    repeat (3) @(posedge clock);
    #1;
    cmp(0, rv0, rd0, '{1'b0, 4'h0});
    cmp(1, rv1, rd1, '{1'b0, 4'h0});
    reset_n = 1;
    cycle(1, 5, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 5, 4'hA, 4'hF, 0);
    cycle(1, 5, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 5, 4'h5, 4'b0011, 0);
    cycle(1, 5, 0, 0, 0, 0, 0);
    idle(3);
    cycle(0, 0, 1, 9, 4'hF, 4'b0100, 0);
    cycle(1, 9, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 3, 4'h6, 4'hF, 0);
    cycle(1, 3, 1, 3, 4'h9, 4'b1000, 0);
    cycle(0, 0, 1, 1, 4'h7, 4'hF, 0);
    cycle(0, 0, 1, 2, 4'h7, 4'hF, 0);
    cycle(0, 0, 1, 2, 4'h3, 4'hF, 1);
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 2, 0, 0, 0, 0, 0);
    cycle(1, 2, 0, 0, 0, 0, 0);
    #2 reset_n = 0;
    R0_en = 0; W0_en = 0; flush = 0;
    #1;
    cmp(0, rv0, rd0, '{1'b0, 4'h0});
    cmp(1, rv1, rd1, '{1'b0, 4'h0});
    q0.delete();
    q1.delete();
    model_clear();
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    cycle(1, 2, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 120, 4'hB, 4'hF, 0);
    cycle(1, 120, 0, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 800; i++) begin
      logic [6:0] ra, wa;
      ra = ($urandom % 4 == 0) ? 7'($urandom_range(96, 127)) : 7'($urandom_range(0, 15));
      wa = ($urandom % 4 == 0) ? ra
         : (($urandom % 4 == 0) ? 7'($urandom_range(96, 127)) : 7'($urandom_range(0, 15)));
      cycle(1'($urandom % 4 != 0), ra, 1'($urandom % 2), wa, 4'($urandom), 4'($urandom),
            1'($urandom % 40 == 0));
    end
    idle(2);
    @(negedge clock);
    #1;
    checks++;
    if (q0.size() + q1.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d exp 0", q0.size() + q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
